// File: rtl/spi_slave_fsm_if.sv
// SPI pins plus received-byte and FSM-state outputs of spi_slave_fsm.
// master drives the SPI wires; slave is the spi_slave_fsm side.
interface spi_slave_fsm_if;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic [7:0] state;
   logic       state_en;

   modport master (
      output sclk, cs_n, mosi,
      input  miso, rx_dv, rx_byte, state, state_en
   );

   modport slave (
      input  sclk, cs_n, mosi,
      output miso, rx_dv, rx_byte, state, state_en
   );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave with a Moore "101" detector fed by bit 0 of each byte.
// Define SPI_MISO_TRISTATE_EN to float MISO while chip select is high.
module spi_slave_fsm #(
   parameter int SPI_MODE = 0
) (
   input logic              clk,
   input logic              rst,
   spi_slave_fsm_if.slave   bus
);

   localparam logic [1:0] MODE = SPI_MODE[1:0];
   localparam logic       CPOL = MODE[1];
   localparam logic       CPHA = MODE[0];

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_t;

   logic [2:0] sclk_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   logic       sclk_rise;
   logic       sclk_fall;
   logic       lead_e;
   logic       trail_e;
   logic       sample_e;
   logic       shift_e;
   logic       cs_s;
   logic       cs_fall;
   logic       mosi_s;

   logic [2:0] bit_cnt;
   logic [7:0] rx_sr;
   logic [7:0] rx_byte;
   logic       rx_dv;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] state_out;
   logic       state_en;

   logic [7:0] tx_byte;
   logic [7:0] load_val;
   logic [7:0] tx_sr;
   logic [2:0] tx_cnt;
   logic       miso_r;
   logic       tx_bit;

   // two-flop synchronisers; the third sclk/cs flop is the edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q <= {3{CPOL}};
         cs_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], bus.sclk};
         cs_q   <= {cs_q[1:0], bus.cs_n};
         mosi_q <= {mosi_q[0], bus.mosi};
      end
   end

   always_comb begin
      sclk_rise = sclk_q[1] & ~sclk_q[2];
      sclk_fall = ~sclk_q[1] & sclk_q[2];
      lead_e    = CPOL ? sclk_fall : sclk_rise;
      trail_e   = CPOL ? sclk_rise : sclk_fall;
      sample_e  = CPHA ? trail_e : lead_e;
      shift_e   = CPHA ? lead_e : trail_e;
      cs_s      = cs_q[1];
      cs_fall   = cs_q[2] & ~cs_q[1];
      mosi_s    = mosi_q[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= 3'd0;
         rx_sr   <= 8'h00;
         rx_byte <= 8'h00;
         rx_dv   <= 1'b0;
      end else begin
         rx_dv <= 1'b0;
         if (cs_s) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 8'h00;
         end else if (sample_e) begin
            rx_sr   <= {rx_sr[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_byte <= {rx_sr[6:0], mosi_s};
               rx_dv   <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S0;
         state_en <= 1'b0;
      end else begin
         state_q  <= state_d;
         state_en <= rx_dv;
      end
   end

   // 8'hFF is the state query and never advances the detector
   always_comb begin
      state_d = state_q;
      if (rx_dv && (rx_byte != 8'hFF)) begin
         unique case (state_q)
            S0: state_d = rx_byte[0] ? S1 : S0;
            S1: state_d = rx_byte[0] ? S1 : S2;
            S2: state_d = rx_byte[0] ? S3 : S0;
            S3: state_d = rx_byte[0] ? S1 : S2;
            default: state_d = S0;
         endcase
      end
   end

   always_comb begin
      state_out = {6'b0, state_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_byte <= 8'h00;
      end else if (rx_dv) begin
         tx_byte <= {6'b0, state_d};
      end
   end

   // bypass so a load racing a state update still sees the new state
   always_comb begin
      load_val = rx_dv ? {6'b0, state_d} : tx_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr  <= 8'h00;
         tx_cnt <= 3'd0;
         miso_r <= 1'b0;
      end else if (cs_s) begin
         tx_cnt <= 3'd0;
         miso_r <= 1'b0;
      end else if (cs_fall) begin
         tx_sr  <= load_val;
         tx_cnt <= 3'd0;
         miso_r <= 1'b0;
      end else if (shift_e) begin
         tx_cnt <= tx_cnt + 3'd1;
         if (CPHA) begin
            miso_r <= tx_sr[7];
         end
         if (tx_cnt == 3'd7) begin
            tx_sr <= load_val;
         end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
      end
   end

   // CPHA=0 presents the MSB straight after the load
   always_comb begin
      tx_bit = CPHA ? miso_r : tx_sr[7];
   end

`ifdef SPI_MISO_TRISTATE_EN
   assign bus.miso = cs_s ? 1'bz : tx_bit;
`else
   assign bus.miso = cs_s ? 1'b0 : tx_bit;
`endif

   assign bus.rx_dv    = rx_dv;
   assign bus.rx_byte  = rx_byte;
   assign bus.state    = state_out;
   assign bus.state_en = state_en;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: mode 0 and mode 3 instances.
// Checks received bytes, detector states and returned MISO bytes.
module tb_spi_slave_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #10 clk = ~clk;

   spi_slave_fsm_if b0 ();
   spi_slave_fsm_if b3 ();

   spi_slave_fsm #(.SPI_MODE(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   spi_slave_fsm #(.SPI_MODE(3)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3)
   );

   int n_run  = 0;
   int n_fail = 0;

   int dv0 = 0, en0 = 0, seq0 = 0;
   int dv3 = 0, en3 = 0, seq3 = 0;
   logic [7:0] byte0 = 8'h00, st0 = 8'h00;
   logic [7:0] byte3 = 8'h00, st3 = 8'h00;
   logic       pdv0 = 1'b0, pdv3 = 1'b0;

   // state_en must always follow rx_dv by exactly one cycle
   always @(negedge clk) begin
      if (b0.rx_dv) begin
         dv0++;
         byte0 = b0.rx_byte;
      end
      if (b0.state_en) begin
         en0++;
         st0 = b0.state;
         if (!pdv0) seq0++;
      end
      pdv0 = b0.rx_dv;
      if (b3.rx_dv) begin
         dv3++;
         byte3 = b3.rx_byte;
      end
      if (b3.state_en) begin
         en3++;
         st3 = b3.state;
         if (!pdv3) seq3++;
      end
      pdv3 = b3.rx_dv;
   end

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic xfer0(input logic [15:0] d, input int nb,
                        output logic [15:0] q);
      q = 16'h0000;
      b0.cs_n = 1'b0;
      #200;
      for (int i = 0; i < nb; i++) begin
         b0.mosi = d[nb-1-i];
         #200;
         b0.sclk = 1'b1;
         q = {q[14:0], b0.miso};
         #200;
         b0.sclk = 1'b0;
      end
      #200;
      b0.cs_n = 1'b1;
      #400;
   endtask

   task automatic xfer3(input logic [15:0] d, input int nb,
                        output logic [15:0] q);
      q = 16'h0000;
      b3.cs_n = 1'b0;
      #200;
      for (int i = 0; i < nb; i++) begin
         b3.sclk = 1'b0;
         b3.mosi = d[nb-1-i];
         #200;
         b3.sclk = 1'b1;
         q = {q[14:0], b3.miso};
         #200;
      end
      #200;
      b3.cs_n = 1'b1;
      #400;
   endtask

   task automatic run0(input logic [7:0] b, input logic [7:0] st,
                       input logic [7:0] mi);
      int bd, be;
      logic [15:0] q;
      bd = dv0;
      be = en0;
      xfer0({8'h00, b}, 8, q);
      chk("m0 dv count", 16'(dv0 - bd), 16'd1);
      chk("m0 rx_byte", {8'h00, byte0}, {8'h00, b});
      chk("m0 en count", 16'(en0 - be), 16'd1);
      chk("m0 state", {8'h00, st0}, {8'h00, st});
      chk("m0 miso byte", q, {8'h00, mi});
      chk("m0 miso idle", {15'h0, b0.miso}, 16'h0000);
   endtask

   task automatic run3(input logic [7:0] b, input logic [7:0] st,
                       input logic [7:0] mi);
      int bd, be;
      logic [15:0] q;
      bd = dv3;
      be = en3;
      xfer3({8'h00, b}, 8, q);
      chk("m3 dv count", 16'(dv3 - bd), 16'd1);
      chk("m3 rx_byte", {8'h00, byte3}, {8'h00, b});
      chk("m3 en count", 16'(en3 - be), 16'd1);
      chk("m3 state", {8'h00, st3}, {8'h00, st});
      chk("m3 miso byte", q, {8'h00, mi});
   endtask

   // {byte sent, state after, byte returned on MISO}
   logic [23:0] seq_a [5] = '{
      24'hA5_01_00, 24'h01_01_01, 24'h00_02_01,
      24'h01_03_02, 24'hFF_03_03
   };
   logic [23:0] seq_b [8] = '{
      24'h01_01_03, 24'h00_02_01, 24'h00_00_02, 24'h00_00_00,
      24'h01_01_00, 24'h00_02_01, 24'h01_03_02, 24'h00_02_03
   };

   initial begin
      int bd, be;
      logic [15:0] q;
      b0.sclk = 1'b0;
      b0.cs_n = 1'b1;
      b0.mosi = 1'b0;
      b3.sclk = 1'b1;
      b3.cs_n = 1'b1;
      b3.mosi = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst state", {8'h00, b0.state}, 16'h0000);
      chk("rst rx_dv", {15'h0, b0.rx_dv}, 16'h0000);
      chk("rst state_en", {15'h0, b0.state_en}, 16'h0000);
      chk("rst rx_byte", {8'h00, b0.rx_byte}, 16'h0000);
      chk("rst miso", {15'h0, b0.miso}, 16'h0000);
      chk("rst m3 state", {8'h00, b3.state}, 16'h0000);
      chk("rst m3 miso", {15'h0, b3.miso}, 16'h0000);
      repeat (4) @(negedge clk);

      foreach (seq_a[i])
         run0(seq_a[i][23:16], seq_a[i][15:8], seq_a[i][7:0]);

      bd = dv0;
      be = en0;
      xfer0(16'h0016, 5, q);
      chk("abort dv count", 16'(dv0 - bd), 16'd0);
      chk("abort en count", 16'(en0 - be), 16'd0);
      chk("abort state", {8'h00, b0.state}, 16'h0003);
      chk("abort miso", q, 16'h0000);

      foreach (seq_b[i])
         run0(seq_b[i][23:16], seq_b[i][15:8], seq_b[i][7:0]);

      bd = dv0;
      be = en0;
      xfer0(16'h0100, 16, q);
      chk("b2b dv count", 16'(dv0 - bd), 16'd2);
      chk("b2b en count", 16'(en0 - be), 16'd2);
      chk("b2b last byte", {8'h00, byte0}, 16'h0000);
      chk("b2b state", {8'h00, st0}, 16'h0002);
      chk("b2b miso", q, 16'h0203);

      run3(8'hA5, 8'h01, 8'h00);
      run3(8'hFF, 8'h01, 8'h01);
      chk("m3 miso idle", {15'h0, b3.miso}, 16'h0000);

      chk("m0 en after dv", 16'(seq0), 16'd0);
      chk("m3 en after dv", 16'(seq3), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
